// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: state encoding,
// default sizing and requester count.
// Imported by the interface, the arbiter core and its grant sub-module.
package alu_arbiter_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_TIMEOUT = 8;
  localparam int NUM_REQ         = 2;
  localparam int FUN_W           = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
  localparam logic [1:0] ST_RESP  = 2'b11;

endpackage : alu_arbiter_pkg

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU-side and response signals of the ALU arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment (requesters plus ALU) driving it.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [NUM_REQ-1:0]       Req_Valid;
  logic [NUM_REQ-1:0]       Req_Ready;
  logic [NUM_REQ*WIDTH-1:0] Req_A;
  logic [NUM_REQ*WIDTH-1:0] Req_B;
  logic [NUM_REQ*FUN_W-1:0] Req_FUN;

  logic [WIDTH-1:0]         ALU_A;
  logic [WIDTH-1:0]         ALU_B;
  logic [FUN_W-1:0]         ALU_FUN;
  logic                     ALU_Enable;
  logic [WIDTH-1:0]         ALU_OUT;
  logic                     ALU_Valid;

  logic [NUM_REQ-1:0]       Rsp_Valid;
  logic [NUM_REQ-1:0]       Rsp_Ready;
  logic [WIDTH-1:0]         Rsp_Data;
  logic                     Rsp_Error;
  logic                     Busy;

  modport slave (
    input  Req_Valid, Req_A, Req_B, Req_FUN, ALU_OUT, ALU_Valid, Rsp_Ready,
    output Req_Ready, ALU_A, ALU_B, ALU_FUN, ALU_Enable,
           Rsp_Valid, Rsp_Data, Rsp_Error, Busy
  );

  modport master (
    output Req_Valid, Req_A, Req_B, Req_FUN, ALU_OUT, ALU_Valid, Rsp_Ready,
    input  Req_Ready, ALU_A, ALU_B, ALU_FUN, ALU_Enable,
           Rsp_Valid, Rsp_Data, Rsp_Error, Busy
  );

endinterface : alu_arbiter_if

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant, purely combinational (zero latency).
// A lone request always wins; on contention the pointer picks the winner.
// No state and no backpressure: the pointer register lives in the parent.
module rr_arbiter_2
  import alu_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  // One-hot grant; pointer only matters when both requesters are active
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule : rr_arbiter_2

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one ALU, one transaction at a time.
// Latency: accept T, ALU_Enable T+1, earliest ALU_Valid T+2, Rsp_Valid T+3.
// Backpressure: Req_Ready only in IDLE; response held until granted Rsp_Ready.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
)(
  input  logic          CLK,
  input  logic          RST,
  alu_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]         state_q, state_d;
  logic               ptr_q,   ptr_d;
  logic               gnt_q,   gnt_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [FUN_W-1:0]   fun_q,   fun_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic               err_q,   err_d;

  logic [NUM_REQ-1:0] gnt_vec;
  logic               gnt_idx;
  logic [NUM_REQ-1:0] req_ready;
  logic               req_xfer;

  rr_arbiter_2 u_rr (
    .req_i (bus.Req_Valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_vec)
  );

  assign gnt_idx   = gnt_vec[1];
  assign req_ready = (state_q == ST_IDLE) ? gnt_vec : '0;
  assign req_xfer  = |(bus.Req_Valid & req_ready);

  // Next-state and datapath capture for the IDLE/ISSUE/WAIT/RESP sequence
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_xfer) begin
          a_d     = gnt_idx ? bus.Req_A[2*WIDTH-1:WIDTH] : bus.Req_A[WIDTH-1:0];
          b_d     = gnt_idx ? bus.Req_B[2*WIDTH-1:WIDTH] : bus.Req_B[WIDTH-1:0];
          fun_d   = gnt_idx ? bus.Req_FUN[2*FUN_W-1:FUN_W] : bus.Req_FUN[FUN_W-1:0];
          gnt_d   = gnt_idx;
          ptr_d   = ~gnt_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving in the last allowed cycle still beats the timeout
        if (bus.ALU_Valid) begin
          data_d  = bus.ALU_OUT;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.Rsp_Ready[gnt_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers; reset abandons any in-flight transaction
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.Req_Ready  = req_ready;
  assign bus.ALU_A      = a_q;
  assign bus.ALU_B      = b_q;
  assign bus.ALU_FUN    = fun_q;
  assign bus.ALU_Enable = (state_q == ST_ISSUE);
  assign bus.Rsp_Valid  = (state_q == ST_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.Rsp_Data   = data_q;
  assign bus.Rsp_Error  = err_q;
  assign bus.Busy       = (state_q != ST_IDLE);

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, contention, single request,
// timeout, timeout boundary, response backpressure and mid-operation reset.
module tb_alu_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  alu_arbiter_if #(.WIDTH(16)) bus ();

  alu_arbiter #(.WIDTH(16), .TIMEOUT(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  logic [58:0] all_outs;
  assign all_outs = {bus.Req_Ready, bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.ALU_Enable,
                     bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Error, bus.Busy};

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled one time unit later, well away from either edge.
  task automatic nxt();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_inputs();
    bus.Req_Valid = '0;
    bus.Req_A     = '0;
    bus.Req_B     = '0;
    bus.Req_FUN   = '0;
    bus.ALU_OUT   = '0;
    bus.ALU_Valid = 1'b0;
    bus.Rsp_Ready = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    nxt(); nxt(); #1;
    checks++;
    if (all_outs !== 59'd0) begin
      errors++; $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    RST = 1'b0;
    nxt(); #1;
    checks++;
    if (all_outs !== 59'd0) begin
      errors++; $display("FAIL post_reset_outs: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_oh;
    logic [15:0] exp_a;
    logic [3:0]  exp_f;
    bus.Req_Valid = 2'b11;
    bus.Req_A     = 32'h2222_1111;
    bus.Req_B     = 32'h4444_3333;
    bus.Req_FUN   = 8'hC3;
    bus.Rsp_Ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a  = (k % 2 == 0) ? 16'h1111 : 16'h2222;
      exp_f  = (k % 2 == 0) ? 4'h3 : 4'hC;
      #1;
      checks++;
      if (bus.Req_Ready !== exp_oh) begin
        errors++; $display("FAIL cont_grant%0d: got %b expected %b", k, bus.Req_Ready, exp_oh);
      end
      nxt(); bus.ALU_Valid = 1'b0; #1;
      checks++;
      if ({bus.ALU_Enable, bus.ALU_A, bus.ALU_FUN, bus.Req_Ready} !== {1'b1, exp_a, exp_f, 2'b00}) begin
        errors++; $display("FAIL cont_issue%0d: got en=%b a=%h f=%h rdy=%b expected en=1 a=%h f=%h rdy=00",
                           k, bus.ALU_Enable, bus.ALU_A, bus.ALU_FUN, bus.Req_Ready, exp_a, exp_f);
      end
      nxt(); bus.ALU_Valid = 1'b1; bus.ALU_OUT = 16'h0A00 + 16'(k); #1;
      checks++;
      if (bus.Req_Ready !== 2'b00) begin
        errors++; $display("FAIL cont_wait_rdy%0d: got %b expected 00", k, bus.Req_Ready);
      end
      nxt(); bus.ALU_Valid = 1'b0; #1;
      checks++;
      if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Req_Ready} !== {exp_oh, 16'h0A00 + 16'(k), 2'b00}) begin
        errors++; $display("FAIL cont_resp%0d: got v=%b d=%h rdy=%b expected v=%b d=%h rdy=00",
                           k, bus.Rsp_Valid, bus.Rsp_Data, bus.Req_Ready, exp_oh, 16'h0A00 + 16'(k));
      end
      nxt();
    end
    clear_inputs();
  endtask

  task automatic test_single();
    bus.Req_Valid = 2'b01; bus.Req_A = 32'd5; bus.Req_B = 32'd3; bus.Req_FUN = 8'h00; #1;
    checks++;
    if (bus.Req_Ready !== 2'b01) begin
      errors++; $display("FAIL single_ready: got %b expected 01", bus.Req_Ready);
    end
    nxt(); bus.Req_Valid = 2'b00; #1;
    checks++;
    if ({bus.ALU_Enable, bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.Busy} !== {1'b1, 16'd5, 16'd3, 4'h0, 1'b1}) begin
      errors++; $display("FAIL single_issue: got en=%b a=%h b=%h f=%h busy=%b expected en=1 a=5 b=3 f=0 busy=1",
                         bus.ALU_Enable, bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.Busy);
    end
    nxt(); bus.ALU_Valid = 1'b1; bus.ALU_OUT = 16'd8; #1;
    checks++;
    if ({bus.ALU_Enable, bus.Rsp_Valid} !== 3'b000) begin
      errors++; $display("FAIL single_wait: got en=%b v=%b expected en=0 v=00", bus.ALU_Enable, bus.Rsp_Valid);
    end
    nxt(); bus.ALU_Valid = 1'b0; bus.Rsp_Ready = 2'b01; #1;
    checks++;
    if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Error} !== {2'b01, 16'd8, 1'b0}) begin
      errors++; $display("FAIL single_resp: got v=%b d=%h e=%b expected v=01 d=0008 e=0",
                         bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Error);
    end
    nxt(); bus.Rsp_Ready = 2'b00; #1;
    checks++;
    if ({bus.Busy, bus.Rsp_Valid} !== 3'b000) begin
      errors++; $display("FAIL single_done: got busy=%b v=%b expected 0/00", bus.Busy, bus.Rsp_Valid);
    end
  endtask

  // Shared by the timeout and boundary scenarios: late=1 raises ALU_Valid
  // exactly in the eighth WAIT cycle.
  task automatic run_timeout(input logic [1:0] req, input logic late, input string nm);
    bus.Req_Valid = req; bus.Req_A = 32'h0007_0007; bus.Req_B = 32'h0009_0009; bus.Req_FUN = 8'hAA; #1;
    checks++;
    if (bus.Req_Ready !== req) begin
      errors++; $display("FAIL %s_ready: got %b expected %b", nm, bus.Req_Ready, req);
    end
    nxt(); bus.Req_Valid = 2'b00; #1;
    checks++;
    if ({bus.ALU_Enable, bus.ALU_FUN} !== 5'b1_1010) begin
      errors++; $display("FAIL %s_issue: got en=%b f=%h expected en=1 f=a", nm, bus.ALU_Enable, bus.ALU_FUN);
    end
    for (int i = 0; i < 8; i++) begin
      nxt();
      bus.ALU_Valid = late && (i == 7);
      bus.ALU_OUT   = late ? 16'hBEEF : 16'hDEAD;
      #1;
      checks++;
      if ({bus.Rsp_Valid, bus.Busy, bus.ALU_Enable} !== 4'b0010) begin
        errors++; $display("FAIL %s_wait%0d: got v=%b busy=%b en=%b expected v=00 busy=1 en=0",
                           nm, i, bus.Rsp_Valid, bus.Busy, bus.ALU_Enable);
      end
    end
    nxt(); bus.ALU_Valid = 1'b0; bus.Rsp_Ready = req; #1;
    checks++;
    if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Error} !== {req, (late ? 16'hBEEF : 16'h0000), ~late}) begin
      errors++; $display("FAIL %s_resp: got v=%b d=%h e=%b expected v=%b d=%h e=%b", nm,
                         bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Error, req, (late ? 16'hBEEF : 16'h0000), ~late);
    end
    nxt(); bus.Rsp_Ready = 2'b00; #1;
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++; $display("FAIL %s_done: got busy=%b expected 0", nm, bus.Busy);
    end
  endtask

  task automatic test_timeout();
    run_timeout(2'b10, 1'b0, "timeout");
  endtask

  task automatic test_boundary();
    run_timeout(2'b01, 1'b1, "boundary");
  endtask

  task automatic test_backpressure();
    bus.Req_Valid = 2'b01; bus.Req_A = 32'h0000_0010; bus.Req_B = 32'h0000_0020; bus.Req_FUN = 8'h05;
    nxt(); bus.Req_Valid = 2'b00;
    nxt(); bus.ALU_Valid = 1'b1; bus.ALU_OUT = 16'h1234;
    for (int j = 0; j < 5; j++) begin
      nxt();
      bus.Rsp_Ready = 2'b10;
      bus.ALU_Valid = (j == 2);
      bus.ALU_OUT   = 16'hFFFF;
      #1;
      checks++;
      if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Error, bus.Busy} !== {2'b01, 16'h1234, 1'b0, 1'b1}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h e=%b busy=%b expected v=01 d=1234 e=0 busy=1",
                           j, bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Error, bus.Busy);
      end
    end
    nxt(); bus.ALU_Valid = 1'b0; bus.Rsp_Ready = 2'b01; #1;
    checks++;
    if ({bus.Rsp_Valid, bus.Rsp_Data} !== {2'b01, 16'h1234}) begin
      errors++; $display("FAIL bp_release: got v=%b d=%h expected v=01 d=1234", bus.Rsp_Valid, bus.Rsp_Data);
    end
    nxt(); bus.Rsp_Ready = 2'b00; #1;
    checks++;
    if ({bus.Busy, bus.Rsp_Valid} !== 3'b000) begin
      errors++; $display("FAIL bp_done: got busy=%b v=%b expected 0/00", bus.Busy, bus.Rsp_Valid);
    end
  endtask

  task automatic test_mid_reset();
    bus.Req_Valid = 2'b01; bus.Req_A = 32'h0000_0077; bus.Req_B = 32'h0000_0066; bus.Req_FUN = 8'h0F;
    nxt(); bus.Req_Valid = 2'b00;
    nxt(); RST = 1'b1;
    nxt(); RST = 1'b0; #1;
    checks++;
    if (all_outs !== 59'd0) begin
      errors++; $display("FAIL midrst_outs: got %h expected 0", all_outs);
    end
    for (int j = 0; j < 3; j++) begin
      nxt(); bus.ALU_Valid = 1'b1; bus.ALU_OUT = 16'h5555; bus.Rsp_Ready = 2'b11; #1;
      checks++;
      if ({bus.ALU_Enable, bus.Rsp_Valid, bus.Busy} !== 4'b0000) begin
        errors++; $display("FAIL midrst_quiet%0d: got en=%b v=%b busy=%b expected 0/00/0",
                           j, bus.ALU_Enable, bus.Rsp_Valid, bus.Busy);
      end
    end
    bus.ALU_Valid = 1'b0; bus.Rsp_Ready = 2'b00;
    nxt(); bus.Req_Valid = 2'b11; #1;
    checks++;
    if (bus.Req_Ready !== 2'b01) begin
      errors++; $display("FAIL midrst_grant: got %b expected 01", bus.Req_Ready);
    end
    nxt(); bus.Req_Valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_boundary();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_arbiter
